owl_master_ctrl: RTL and testbench

Single-wire (OWL) bus master for the D05200 smoke-detector ASIC. It converts a parallel SFR command (read/write, 7-bit address, 8-bit count, 8-bit data) into a serial frame on the open-drain OWL line, which has an external pull-up and is wired-AND with the slave. It is used in test and calibration flows to program SFRs such as mode, PWM prescaler, calibration points and point mode, and to read them back.

---
 rtl/owl_master_ctrl.sv | 167 ++++++++++++++++
 tb/tb_owl_master_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/owl_master_ctrl.sv
// Single-wire OWL bus master: turns a stable SFR command tuple into a break/header/data frame
// on the open-drain line. Define OWL_MCTRL_PARITY_EN to add an even-parity cell after every byte.
//   state | meaning
//   IDLE  | line released, waiting for a new stable tuple or a pending one
//   BRK   | frame-start break, line low
//   GAP1  | released gap after break
//   HDR   | 16 header bits: rw, addr, num
//   DATA  | num+1 data bytes, written or read
//   GAP2  | released gap after last bit
module owl_master_ctrl #(
  parameter int BRK_CYC = 8,
  parameter int GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sfr_cmd_w,
  input  logic       sfr_wen,
  input  logic [6:0] sfr_addrs_w,
  input  logic [7:0] sfr_num_w,
  input  logic [7:0] sfr_wdata_w,
  inout  wire        owl_inout,
  output logic       busy,
  output logic [7:0] rdata,
  output logic       rdata_vld
);

  typedef enum logic [2:0] {S_IDLE, S_BRK, S_GAP1, S_HDR, S_DATA, S_GAP2} state_t;

  localparam logic [15:0] BRK_LD = 16'(BRK_CYC - 1);
  localparam logic [15:0] GAP_LD = 16'(GAP_CYC - 1);
`ifdef OWL_MCTRL_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
  logic [7:0]  shreg;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
  logic [6:0]  shreg;
`endif

  state_t      state, state_nxt;
  logic [24:0] t_live, t_q, t_last, t_pend;
  logic        pend_vld, launch_ok, start;
  logic [15:0] tmr;
  logic [1:0]  cyc;
  logic [3:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [7:0]  cur_byte;
  logic        cell_end, byte_end, rd_cell, tx_bit, owl_low, owl_in;

  // tuple layout: cmd | wen | addr[6:0] | num[7:0] | wdata[7:0]
  assign t_live    = {sfr_cmd_w, sfr_wen, sfr_addrs_w, sfr_num_w, sfr_wdata_w};
  assign launch_ok = t_q[24] && (t_q == t_live) && (t_q != t_last);

  assign cur_byte = (state == S_HDR) ? (byte_cnt[0] ? t_last[15:8] : t_last[23:16]) : t_last[7:0];
  assign tx_bit   = bit_cnt[3] ? ^cur_byte : cur_byte[3'd7 - bit_cnt[2:0]];
  assign cell_end = (cyc == 2'd3);
  assign byte_end = cell_end && (bit_cnt == LAST_BIT);
  assign rd_cell  = (state == S_DATA) && !t_last[23];

  // every cell opens low; write-0 stays low 3 cycles, write-1 and read cells release after 1
  assign owl_low = (state == S_BRK) ||
                   (((state == S_HDR) || (state == S_DATA)) &&
                    ((cyc == 2'd0) || (!rd_cell && !tx_bit && (cyc != 2'd3))));

  assign owl_inout = owl_low ? 1'b0 : 1'bz;
  assign owl_in    = owl_inout;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      S_IDLE: if (pend_vld || launch_ok) begin
        state_nxt = S_BRK;
        start     = 1'b1;
      end
      S_BRK:  if (tmr == 16'd0) state_nxt = S_GAP1;
      S_GAP1: if (tmr == 16'd0) state_nxt = S_HDR;
      S_HDR:  if (byte_end && byte_cnt[0]) state_nxt = S_DATA;
      S_DATA: if (byte_end && (byte_cnt == t_last[15:8])) state_nxt = S_GAP2;
      S_GAP2: if (tmr == 16'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // pending slot wins over the live tuple so a held input cannot starve it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q      <= '0;
      t_last   <= '0;
      t_pend   <= '0;
      pend_vld <= 1'b0;
    end else begin
      t_q <= t_live;
      if (start) begin
        t_last   <= pend_vld ? t_pend : t_q;
        pend_vld <= 1'b0;
      end else if (busy && launch_ok) begin
        t_pend   <= t_q;
        pend_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr      <= '0;
      cyc      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cyc      <= '0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          if (start) tmr <= BRK_LD;
        end
        S_BRK: tmr <= (tmr == 16'd0) ? GAP_LD : tmr - 16'd1;
        S_GAP1, S_GAP2: if (tmr != 16'd0) tmr <= tmr - 16'd1;
        S_HDR, S_DATA: begin
          cyc <= cyc + 2'd1;
          if (byte_end) begin
            bit_cnt  <= '0;
            byte_cnt <= ((state == S_HDR) && byte_cnt[0]) ? 8'd0 : byte_cnt + 8'd1;
          end else if (cell_end) begin
            bit_cnt <= bit_cnt + 4'd1;
          end
          if ((state == S_DATA) && (state_nxt == S_GAP2)) tmr <= GAP_LD;
        end
        default: ;
      endcase
    end
  end

  // read bits are sampled at the edge closing cycle 2 of the cell
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      rdata     <= '0;
      rdata_vld <= 1'b0;
    end else begin
      rdata_vld <= 1'b0;
      if (rd_cell && (cyc == 2'd2)) begin
`ifdef OWL_MCTRL_PARITY_EN
        if (bit_cnt[3]) begin
          rdata     <= shreg;
          rdata_vld <= ((^shreg) == owl_in);
        end else begin
          shreg <= {shreg[6:0], owl_in};
        end
`else
        shreg <= {shreg[5:0], owl_in};
        if (bit_cnt[2:0] == 3'd7) begin
          rdata     <= {shreg, owl_in};
          rdata_vld <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_owl_master_ctrl.sv
// Directed bench for owl_master_ctrl: a scoreboard of expected frames (length, low-pulse widths)
// and read bytes, filled when stimulus is driven and drained by a line monitor.
module tb_owl_master_ctrl;

  localparam int BRK = 8;
  localparam int GAP = 2;
`ifdef OWL_MCTRL_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd = 1'b0, wen = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] num = '0, wdata = '0;
  wire        owl;
  logic       slave_low = 1'b0;
  logic       busy, rdata_vld;
  logic [7:0] rdata;

  pullup (owl);
  assign owl = slave_low ? 1'b0 : 1'bz;

  owl_master_ctrl #(.BRK_CYC(BRK), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst),
    .sfr_cmd_w(cmd), .sfr_wen(wen), .sfr_addrs_w(addr),
    .sfr_num_w(num), .sfr_wdata_w(wdata),
    .owl_inout(owl), .busy(busy), .rdata(rdata), .rdata_vld(rdata_vld)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_bad = 0;
  int         exp_w[$], exp_n[$], exp_len[$];
  logic [7:0] exp_rd[$];
  int         got_w[$];
  int         run = 0, blen = 0;
  logic       busy_d = 1'b0;
  bit         skip_next = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_bits(input logic [7:0] b, inout int cnt);
    for (int i = 7; i >= 0; i--) begin
      exp_w.push_back(b[i] ? 1 : 3);
      cnt++;
    end
    if (PB == 1) begin
      exp_w.push_back((^b) ? 1 : 3);
      cnt++;
    end
  endtask

  // byte k of the data phase is b0 for even k, b1 for odd k
  task automatic push_frame(input logic rw, input logic [6:0] a, input logic [7:0] n,
                            input logic [7:0] b0, input logic [7:0] b1);
    int cnt;
    cnt = 1;
    exp_w.push_back(BRK);
    push_bits({rw, a}, cnt);
    push_bits(n, cnt);
    for (int k = 0; k <= int'(n); k++) push_bits((k % 2 == 1) ? b1 : b0, cnt);
    exp_n.push_back(cnt);
    exp_len.push_back(BRK + 2 * GAP + (int'(n) + 3) * (8 + PB) * 4);
  endtask

  task automatic drive(input logic c, input logic w, input logic [6:0] a,
                       input logic [7:0] n, input logic [7:0] d);
    cmd = c; wen = w; addr = a; num = n; wdata = d;
  endtask

  task automatic wait_busy_rise(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    check(tag, busy, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic slave_bit(input logic v);
    if (!v) slave_low = 1'b1;
    repeat (3) @(posedge clk);
    #1 slave_low = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // called at the negedge right after busy rose; answers the data cells of a read frame
  task automatic slave_bytes(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] b;
    repeat (BRK + GAP + 2 * (8 + PB) * 4) @(posedge clk);
    #1;
    for (int k = 0; k < nbytes; k++) begin
      b = (k % 2 == 1) ? b1 : b0;
      for (int i = 7; i >= 0; i--) slave_bit(b[i]);
      if (PB == 1) slave_bit(^b);
    end
  endtask

  task automatic frame_end();
    int n, g;
    if (skip_next) begin
      skip_next = 1'b0;
    end else if (exp_n.size() == 0) begin
      check("frame_unexpected_len", blen, 0);
    end else begin
      n = exp_n.pop_front();
      check("frame_len", blen, exp_len.pop_front());
      check("pulse_count", got_w.size(), n);
      for (int i = 0; i < n; i++) begin
        g = (i < got_w.size()) ? got_w[i] : -1;
        check("pulse_width", g, exp_w.pop_front());
      end
    end
    got_w.delete();
    run  = 0;
    blen = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (busy) blen++;
      if (busy || run > 0) begin
        if (owl === 1'b0) run++;
        else if (run > 0) begin
          got_w.push_back(run);
          run = 0;
        end
      end
      if (busy_d && !busy) frame_end();
      busy_d = busy;
      if (rdata_vld) begin
        if (exp_rd.size() == 0) check("rdata_vld_unexpected", rdata_vld, 1'b0);
        else check("rdata", rdata, exp_rd.pop_front());
      end
    end
  end

  initial begin
    int hc;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_vld", rdata_vld, 1'b0);
    check("rst_owl", owl, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic write, launch latency
    push_frame(1'b1, 7'h04, 8'h00, 8'h09, 8'h09);
    drive(1'b1, 1'b1, 7'h04, 8'h00, 8'h09);
    @(negedge clk);
    check("launch_edge1", busy, 1'b0);
    @(negedge clk);
    check("launch_edge2", busy, 1'b1);
    wait_idle("wr_done");
    @(negedge clk);
    check("idle_owl", owl, 1'b1);

    // reads
    push_frame(1'b0, 7'h26, 8'h00, 8'h10, 8'h10);
    exp_rd.push_back(8'h10);
    drive(1'b1, 1'b0, 7'h26, 8'h00, 8'h00);
    wait_busy_rise("rd1_start");
    slave_bytes(1, 8'h10, 8'h10);
    wait_idle("rd1_done");

    push_frame(1'b0, 7'h27, 8'h01, 8'hA5, 8'h3C);
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h3C);
    drive(1'b1, 1'b0, 7'h27, 8'h01, 8'h00);
    wait_busy_rise("rd2_start");
    slave_bytes(2, 8'hA5, 8'h3C);
    wait_idle("rd2_done");
    check("rd2_rdata_hold", rdata, 8'h3C);

    // pending slot: B queued behind A, then C overwritten by D while B runs
    push_frame(1'b1, 7'h28, 8'h00, 8'h5B, 8'h5B);
    drive(1'b1, 1'b1, 7'h28, 8'h00, 8'h5B);
    wait_busy_rise("pa_start");
    repeat (30) @(negedge clk);
    push_frame(1'b1, 7'h29, 8'h01, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 7'h29, 8'h01, 8'h00);
    wait_idle("pa_done");
    @(negedge clk);
    check("pend_gap_b", busy, 1'b1);
    repeat (20) @(negedge clk);
    drive(1'b1, 1'b1, 7'h2A, 8'h00, 8'h11);
    repeat (20) @(negedge clk);
    push_frame(1'b1, 7'h2B, 8'h00, 8'h22, 8'h22);
    drive(1'b1, 1'b1, 7'h2B, 8'h00, 8'h22);
    wait_idle("pb_done");
    @(negedge clk);
    check("pend_gap_d", busy, 1'b1);
    wait_idle("pd_done");

    // held tuple and cmd=0 must not launch
    hc = 0;
    repeat (10000) begin
      @(negedge clk);
      if (busy) hc++;
    end
    check("hold_no_frame", hc, 0);
    drive(1'b0, 1'b1, 7'h30, 8'h00, 8'h55);
    hc = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy) hc++;
    end
    check("cmd0_no_frame", hc, 0);
    check("hold_owl", owl, 1'b1);

    // reset in cycle 40 of a frame, then relaunch of the held tuple
    skip_next = 1'b1;
    drive(1'b1, 1'b1, 7'h04, 8'h00, 8'h09);
    wait_busy_rise("rs_start");
    repeat (40) @(posedge clk);
    #2;
    check("rs_pre_low", owl, 1'b0);
    rst = 1'b0;
    #1;
    check("rs_owl_rel", owl, 1'b1);
    check("rs_busy", busy, 1'b0);
    check("rs_rdata", rdata, 8'h00);
    push_frame(1'b1, 7'h04, 8'h00, 8'h09, 8'h09);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_busy_rise("rs_relaunch");
    wait_idle("rs_done");

    repeat (5) @(negedge clk);
    check("sb_frames_left", exp_n.size(), 0);
    check("sb_rdata_left", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
